// File: rtl/data_memory_arbiter.sv
// data_memory_arbiter: shares the single data_memory port between the MEM
// stage (port 0) and the loader/debug master (port 1). Each granted request
// is held, presented to memory for exactly one cycle, then answered with a
// one-cycle valid pulse, so side-effecting reads happen once per grant.
// Build option: define ARB_FIXED_PRIORITY_EN to make port 0 always win
// contention (round-robin on a last-owner bit otherwise).
module data_memory_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clock,
    input  logic              reset,

    input  logic              m0_req_in,
    input  logic [ADDR_W-1:0] m0_addr_in,
    input  logic              m0_re_in,
    input  logic              m0_we_in,
    input  logic [1:0]        m0_size_in,
    input  logic [DATA_W-1:0] m0_wdata_in,
    output logic              m0_gnt_out,
    output logic              m0_valid_out,
    output logic [DATA_W-1:0] m0_rdata_out,

    input  logic              m1_req_in,
    input  logic [ADDR_W-1:0] m1_addr_in,
    input  logic              m1_re_in,
    input  logic              m1_we_in,
    input  logic [1:0]        m1_size_in,
    input  logic [DATA_W-1:0] m1_wdata_in,
    output logic              m1_gnt_out,
    output logic              m1_valid_out,
    output logic [DATA_W-1:0] m1_rdata_out,

    output logic [ADDR_W-1:0] mem_addr_out,
    output logic [DATA_W-1:0] mem_wdata_out,
    output logic              mem_re_out,
    output logic              mem_we_out,
    output logic [1:0]        mem_size_out,
    input  logic [DATA_W-1:0] mem_readdata_in
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              re_q, re_d;
    logic              we_q, we_d;
    logic [1:0]        size_q, size_d;
    logic              id_q, id_d;
`ifndef ARB_FIXED_PRIORITY_EN
    logic              last_owner_q, last_owner_d;
`endif

    logic              any_req;
    logic              win_id;
    logic              grant;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              sel_we;
    logic              sel_re;
    logic [1:0]        sel_size;
    logic              access;
    logic              resp_ok;

    // Pick the winning requester and mux its request fields.
    always_comb begin
        any_req = m0_req_in | m1_req_in;
`ifdef ARB_FIXED_PRIORITY_EN
        win_id = ~m0_req_in;
`else
        // On a tie the port that did not own the last grant wins.
        win_id = (m0_req_in & m1_req_in) ? ~last_owner_q : m1_req_in;
`endif
        sel_addr  = win_id ? m1_addr_in  : m0_addr_in;
        sel_wdata = win_id ? m1_wdata_in : m0_wdata_in;
        sel_we    = win_id ? m1_we_in    : m0_we_in;
        sel_size  = win_id ? m1_size_in  : m0_size_in;
        // A request with neither enable set is still treated as a read.
        sel_re    = (win_id ? m1_re_in : m0_re_in) | ~sel_we;
    end

    // Next-state logic: grant from IDLE/RESP, one memory cycle in ACCESS.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        re_d    = re_q;
        we_d    = we_q;
        size_d  = size_q;
        id_d    = id_q;
        grant   = 1'b0;
        case (state_q)
            ST_IDLE, ST_RESP: begin
                if (any_req) begin
                    grant   = 1'b1;
                    state_d = ST_ACCESS;
                    addr_d  = sel_addr;
                    wdata_d = sel_wdata;
                    we_d    = sel_we;
                    re_d    = sel_re & ~sel_we;  // write wins when both set
                    size_d  = sel_size;
                    id_d    = win_id;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                rdata_d = re_q ? mem_readdata_in : '0;
                state_d = ST_RESP;
            end
            default: state_d = ST_IDLE;
        endcase
`ifndef ARB_FIXED_PRIORITY_EN
        last_owner_d = grant ? win_id : last_owner_q;
`endif
    end

    // State and holding registers; reset drops any in-flight access.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            addr_q       <= '0;
            wdata_q      <= '0;
            rdata_q      <= '0;
            re_q         <= 1'b0;
            we_q         <= 1'b0;
            size_q       <= 2'b00;
            id_q         <= 1'b0;
`ifndef ARB_FIXED_PRIORITY_EN
            last_owner_q <= 1'b1;
`endif
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            rdata_q      <= rdata_d;
            re_q         <= re_d;
            we_q         <= we_d;
            size_q       <= size_d;
            id_q         <= id_d;
`ifndef ARB_FIXED_PRIORITY_EN
            last_owner_q <= last_owner_d;
`endif
        end
    end

    // Output decode: memory bus only live in ACCESS, grant/valid masked by reset.
    always_comb begin
        access        = (state_q == ST_ACCESS);
        mem_addr_out  = access ? addr_q  : '0;
        mem_wdata_out = access ? wdata_q : '0;
        mem_size_out  = access ? size_q  : 2'b00;
        mem_re_out    = access & re_q;
        mem_we_out    = access & we_q;

        resp_ok       = (state_q == ST_RESP) & ~reset;
        m0_valid_out  = resp_ok & ~id_q;
        m1_valid_out  = resp_ok & id_q;
        m0_rdata_out  = m0_valid_out ? rdata_q : '0;
        m1_rdata_out  = m1_valid_out ? rdata_q : '0;

        m0_gnt_out    = grant & ~reset & ~win_id;
        m1_gnt_out    = grant & ~reset & win_id;
    end

endmodule

// File: doc/data_memory_arbiter.md
# data_memory_arbiter

Two-port arbiter that shares the single `data_memory` access port between two requesters: port 0 (pipeline MEM stage) and port 1 (loader/debug master). Each access is accepted, registered, presented to `data_memory` for exactly one cycle, and returned with a one-cycle valid pulse. This guarantees that side-effecting reads, such as serial MMIO pops, occur exactly once per granted request. It sits between the processor MEM stage and `data_memory`.

## Interface
Parameters
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width

Ports
- `clock`  in  1  system clock; all state updates on rising edge
- `reset`  in  1  synchronous, active-high reset
- `mN_req_in`  in  1  request from port N (N = 0, 1); held until granted
- `mN_addr_in`  in  32  byte address
- `mN_re_in` / `mN_we_in`  in  1  read / write enable; exactly one set with req
- `mN_size_in`  in  2  access size, passed through (2'b11 = word)
- `mN_wdata_in`  in  32  write data
- `mN_gnt_out`  out  1  request accepted this cycle (combinational)
- `mN_valid_out`  out  1  one-cycle completion pulse
- `mN_rdata_out`  out  32  read data, valid when `mN_valid_out`
- `mem_addr_out`, `mem_wdata_out`  out  32  to `data_memory`
- `mem_re_out`, `mem_we_out`  out  1  to `data_memory`
- `mem_size_out`  out  2  to `data_memory`
- `mem_readdata_in`  in  32  combinational read data from `data_memory`

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE / RESP:
  - If any `req` is high, select a winner, assert its `gnt`, and latch its addr/wdata/re/we/size/id into the holding registers. Go to ACCESS.
  - If no `req` is high, go to IDLE.
- ACCESS (exactly one cycle):
  - Drive `mem_*` from the holding registers.
  - Capture `mem_readdata_in` into the rdata register at the clock edge.
  - Go to RESP.
- RESP:
  - Assert `valid` for the latched id.
  - `rdata` is the captured value for reads and 32'h0 for writes.
  - Grant of the next request is allowed in the same cycle, so back-to-back throughput is 1 access / 2 cycles.
- Outside ACCESS, `mem_re_out` and `mem_we_out` are 0 and `mem_addr_out` / `mem_wdata_out` / `mem_size_out` are 0.
- Arbitration: round-robin on a `last_owner` bit.
  - On a tie, the port that is not `last_owner` wins.
  - `last_owner` updates on every grant; reset value 1, so port 0 wins the first tie.
- A requester whose `req` drops before grant is simply not serviced. Inputs are not sampled after grant.
- `re` and `we` both set with `req`: treated as a write. `re` and `we` both clear with `req`: treated as a read, with `mem_re_out` asserted.

## Timing
- Reset values: FSM = IDLE, `last_owner` = 1, all holding registers 0. All outputs are 0: `gnt`, `valid`, `rdata`, `mem_*`.
- Latency when uncontended:
  - `req` high in cycle 0 → `gnt` in cycle 0.
  - `mem_re_out` / `mem_we_out` in cycle 1.
  - `valid` + `rdata` in cycle 2.
- The write commits at the end of cycle 1.
- Contended requester: granted in the next RESP cycle. Worst-case wait is 2 cycles.
- `gnt` is never asserted in ACCESS. At most one `gnt` and one `valid` are high per cycle.
- Reset asserted mid-operation:
  - Any in-flight access is dropped, with no valid pulse.
  - If reset is high during ACCESS, `mem_we_out` / `mem_re_out` are still driven that cycle. The memory reset governs the write.
  - The next cycle is IDLE.

## Configuration
- `ARB_FIXED_PRIORITY_EN`:
  - Defined: port 0 always wins when both request. `last_owner` is unused. Port 1 may starve.
  - Undefined (default): round-robin as described above.

## Test plan
- Single read: reset, m0 read 0x10000004 where memory holds 0xDEADBEEF → `m0_gnt` in cycle 0, `mem_re_out` = 1 only in cycle 1, `m0_valid` with `m0_rdata` = 0xDEADBEEF in cycle 2.
- Write then read: m1 write 0x7FFFFFF0 ← 0x12345678, then read the same address → first `m1_rdata` = 0, second = 0x12345678.
- Contention: m0 and m1 both request continuously from reset → grants alternate m0, m1, m0, m1 at cycles 0, 2, 4, 6. With `ARB_FIXED_PRIORITY_EN` defined: m0 only.
- Serial side effect: m0 holds `req` for a read of 0xFFFF0004 during 3 stall cycles before grant → exactly one `mem_re_out` pulse and one `serial_rden_out` pulse.
- Reset mid-access: assert reset in ACCESS cycle of an m0 read → no `m0_valid`, and all outputs are 0 the following cycle.
- Idle: no requests for 10 cycles → `mem_re_out` / `mem_we_out` stay 0 and the FSM stays IDLE.
